// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU ops, mul/div ops, forward and
// result selects, and the mul/div FSM state type.
package ex_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [1:0] FWD_E    = 2'd0;
  localparam logic [1:0] FWD_M    = 2'd1;
  localparam logic [1:0] FWD_W    = 2'd2;
  localparam logic [1:0] FWD_RSVD = 2'd3;

  localparam logic [1:0] RES_ALU  = 2'd0;
  localparam logic [1:0] RES_HI   = 2'd1;
  localparam logic [1:0] RES_LO   = 2'd2;
  localparam logic [1:0] RES_LINK = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_t;

  // Bypass selection; the reserved code falls back to the D/E value.
  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                              input logic [XLEN-1:0] e_val,
                                              input logic [XLEN-1:0] m_val,
                                              input logic [XLEN-1:0] w_val);
    logic [XLEN-1:0] r;
    r = e_val;
    case (sel)
      FWD_E, FWD_RSVD: r = e_val;
      FWD_M:           r = m_val;
      FWD_W:           r = w_val;
      default:         r = e_val;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_if.sv
// D/E inputs, forwarding/control and E/M results of the execute stage.
interface ex_if;
  import ex_pkg::*;

  logic [XLEN-1:0]  v1_e;
  logic [XLEN-1:0]  v2_e;
  logic [XLEN-1:0]  e32_e;
  logic [REG_W-1:0] a3_e;
  logic [XLEN-1:0]  pc_e;
  logic [XLEN-1:0]  pc4_e;
  logic [4:0]       shamt_e;
  logic [3:0]       alu_op;
  logic             b_imm;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [XLEN-1:0]  fwd_m_data;
  logic [XLEN-1:0]  fwd_w_data;
  logic [2:0]       md_op;
  logic             md_start;
  logic [1:0]       res_sel;

  logic             md_busy;
  logic [XLEN-1:0]  alu_out_m;
  logic [XLEN-1:0]  v2_m;
  logic [REG_W-1:0] a3_m;
  logic [XLEN-1:0]  pc_m;
  logic [XLEN-1:0]  pc4_m;
  logic             ovf_m;

  modport slave (
    input  v1_e, v2_e, e32_e, a3_e, pc_e, pc4_e, shamt_e, alu_op, b_imm,
           fwd_a_sel, fwd_b_sel, fwd_m_data, fwd_w_data, md_op, md_start, res_sel,
    output md_busy, alu_out_m, v2_m, a3_m, pc_m, pc4_m, ovf_m
  );

  modport master (
    output v1_e, v2_e, e32_e, a3_e, pc_e, pc4_e, shamt_e, alu_op, b_imm,
           fwd_a_sel, fwd_b_sel, fwd_m_data, fwd_w_data, md_op, md_start, res_sel,
    input  md_busy, alu_out_m, v2_m, a3_m, pc_m, pc4_m, ovf_m
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; result is written on the
// edge the busy counter reaches zero.
module md_unit
  import ex_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            md_start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  md_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [XLEN-1:0]  hi_n, lo_n, a_q, a_n, b_q, b_n;
  logic [2:0]       op_q, op_n;

  logic [2*XLEN-1:0] prod_s_c, prod_u_c;
  logic [XLEN-1:0]   quo_s_c, rem_s_c, quo_u_c, rem_u_c;

  assign prod_s_c = {{XLEN{a_q[XLEN-1]}}, a_q} * {{XLEN{b_q[XLEN-1]}}, b_q};
  assign prod_u_c = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
  assign quo_s_c  = XLEN'($signed(a_q) / $signed(b_q));
  assign rem_s_c  = XLEN'($signed(a_q) % $signed(b_q));
  assign quo_u_c  = a_q / b_q;
  assign rem_u_c  = a_q % b_q;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= MD_NONE;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      a_q   <= a_n;
      b_q   <= b_n;
      op_q  <= op_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    case (state)
      S_IDLE: begin
        if (md_start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              a_n = a; b_n = b; op_n = md_op;
              cnt_n   = CNT_W'(MULT_CYCLES);
              state_n = S_MUL;
            end
            MD_DIV, MD_DIVU: begin
              a_n = a; b_n = b; op_n = md_op;
              cnt_n   = CNT_W'(DIV_CYCLES);
              state_n = S_DIV;
            end
            MD_MTHI: hi_n = a;
            MD_MTLO: lo_n = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = S_IDLE;
          {hi_n, lo_n} = (op_q == MD_MULT) ? prod_s_c : prod_u_c;
        end
      end
      S_DIV: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = S_IDLE;
          // Divide by zero leaves HI/LO untouched but still burns the full latency.
          if (b_q != '0) begin
            lo_n = (op_q == MD_DIV) ? quo_s_c : quo_u_c;
            hi_n = (op_q == MD_DIV) ? rem_s_c : rem_u_c;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  issue_while_busy_a: assert property (@(posedge clk) disable iff (reset) !(md_start && busy));

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, mul/div unit and E/M register.
// Optional signed-overflow flag on ovf_m enabled by macro EX_OVF_EN.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  ex_if.slave ex
);

  logic [XLEN-1:0] op_a_c, rt_fwd_c, op_b_c, alu_c, res_c, hi, lo;
  logic            ovf_c, md_busy_q;

  assign op_a_c   = fwd_mux(ex.fwd_a_sel, ex.v1_e, ex.fwd_m_data, ex.fwd_w_data);
  assign rt_fwd_c = fwd_mux(ex.fwd_b_sel, ex.v2_e, ex.fwd_m_data, ex.fwd_w_data);
  assign op_b_c   = ex.b_imm ? ex.e32_e : rt_fwd_c;

  always_comb begin
    alu_c = '0;
    case (ex.alu_op)
      ALU_ADDU: alu_c = op_a_c + op_b_c;
      ALU_SUBU: alu_c = op_a_c - op_b_c;
      ALU_AND:  alu_c = op_a_c & op_b_c;
      ALU_OR:   alu_c = op_a_c | op_b_c;
      ALU_XOR:  alu_c = op_a_c ^ op_b_c;
      ALU_NOR:  alu_c = ~(op_a_c | op_b_c);
      ALU_SLT:  alu_c = XLEN'($signed(op_a_c) < $signed(op_b_c));
      ALU_SLTU: alu_c = XLEN'(op_a_c < op_b_c);
      ALU_LUI:  alu_c = {op_b_c[15:0], 16'h0000};
      ALU_SLL:  alu_c = op_b_c << ex.shamt_e;
      ALU_SRL:  alu_c = op_b_c >> ex.shamt_e;
      ALU_SRA:  alu_c = XLEN'($signed(op_b_c) >>> ex.shamt_e);
      default:  alu_c = '0;
    endcase
  end

`ifdef EX_OVF_EN
  // Signed overflow: result sign disagrees with A when the effective operand signs match.
  always_comb begin
    ovf_c = 1'b0;
    case (ex.alu_op)
      ALU_ADDU: ovf_c = (op_a_c[XLEN-1] == op_b_c[XLEN-1]) && (alu_c[XLEN-1] != op_a_c[XLEN-1]);
      ALU_SUBU: ovf_c = (op_a_c[XLEN-1] != op_b_c[XLEN-1]) && (alu_c[XLEN-1] != op_a_c[XLEN-1]);
      default:  ovf_c = 1'b0;
    endcase
  end
`else
  assign ovf_c = 1'b0;
`endif

  always_comb begin
    res_c = alu_c;
    case (ex.res_sel)
      RES_ALU:  res_c = alu_c;
      RES_HI:   res_c = hi;
      RES_LO:   res_c = lo;
      RES_LINK: res_c = ex.pc4_e + XLEN'(4);
      default:  res_c = alu_c;
    endcase
  end

  md_unit #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_unit (
    .clk     (clk),
    .reset   (reset),
    .md_start(ex.md_start),
    .md_op   (ex.md_op),
    .a       (op_a_c),
    .b       (rt_fwd_c),
    .busy    (md_busy_q),
    .hi      (hi),
    .lo      (lo)
  );

  assign ex.md_busy = ex.md_start | md_busy_q;

  // E/M pipeline register; the memory stage never stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex.alu_out_m <= '0;
      ex.v2_m      <= '0;
      ex.a3_m      <= '0;
      ex.pc_m      <= '0;
      ex.pc4_m     <= '0;
      ex.ovf_m     <= 1'b0;
    end else begin
      ex.alu_out_m <= res_c;
      ex.v2_m      <= rt_fwd_c;
      ex.a3_m      <= ex.a3_e;
      ex.pc_m      <= ex.pc_e;
      ex.pc4_m     <= ex.pc4_e;
      ex.ovf_m     <= ovf_c;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ALU and
// mul/div traffic against an arithmetic reference model.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;
`ifdef EX_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_if ex ();

  ex_stage #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk  (clk),
    .reset(reset),
    .ex   (ex.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex.v1_e = '0; ex.v2_e = '0; ex.e32_e = '0; ex.a3_e = '0;
    ex.pc_e = '0; ex.pc4_e = '0; ex.shamt_e = '0; ex.alu_op = '0;
    ex.b_imm = 1'b0; ex.fwd_a_sel = '0; ex.fwd_b_sel = '0;
    ex.fwd_m_data = '0; ex.fwd_w_data = '0;
    ex.md_op = '0; ex.md_start = 1'b0; ex.res_sel = '0;
  endtask

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] e,
                                          input logic [31:0] m, input logic [31:0] w);
    if (sel == 2'd1) return m;
    if (sel == 2'd2) return w;
    return e;
  endfunction

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b, input int sh);
    longint unsigned p2;
    logic [31:0] r;
    p2 = 64'd1 << sh;
    case (op)
      0:  r = 32'(a + b);
      1:  r = 32'(a - b);
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~(a | b);
      6:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      7:  r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      8:  r = 32'(longint'(b) * 65536);
      9:  r = 32'(longint'(b) * longint'(p2));
      10: r = 32'(longint'(b) / longint'(p2));
      11: r = 32'((longint'(int'(b)) - ((longint'(int'(b)) % longint'(p2) + longint'(p2)) % longint'(p2))) / longint'(p2));
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic ref_ovf(input int op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (!OVF_ON) return 1'b0;
    if (op == 0) s = longint'(int'(a)) + longint'(int'(b));
    else if (op == 1) s = longint'(int'(a)) - longint'(int'(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic check_em(input string tag, input logic [31:0] alu, input logic [31:0] v2,
                          input logic [4:0] a3, input logic [31:0] pc, input logic [31:0] pc4,
                          input logic ovf);
    check({tag, "_alu"}, ex.alu_out_m, alu);
    check({tag, "_v2"},  ex.v2_m, v2);
    check({tag, "_a3"},  32'(ex.a3_m), 32'(a3));
    check({tag, "_pc"},  ex.pc_m, pc);
    check({tag, "_pc4"}, ex.pc4_m, pc4);
    check({tag, "_ovf"}, 32'(ex.ovf_m), 32'(ovf));
  endtask

  // Issue one mul/div op, count busy cycles, and advance the HI/LO model.
  task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc);
    int n;
    idle_inputs();
    ex.v1_e = a; ex.v2_e = b; ex.md_op = op; ex.md_start = 1'b1;
    #1;
    check({tag, "_busy_issue"}, 32'(ex.md_busy), 32'd1);
    step();
    ex.md_start = 1'b0; ex.md_op = '0;
    #1;
    n = 0;
    while (ex.md_busy && n < 50) begin
      n++;
      step();
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
    case (op)
      3'd1: {m_hi, m_lo} = 64'(longint'(int'(a)) * longint'(int'(b)));
      3'd2: {m_hi, m_lo} = 64'(longint'({32'h0, a}) * longint'({32'h0, b}));
      3'd3: if (b != 0) begin m_lo = 32'(int'(a) / int'(b)); m_hi = 32'(int'(a) % int'(b)); end
      3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    idle_inputs();
    ex.res_sel = 2'd1;
    step();
    check({tag, "_hi"}, ex.alu_out_m, exp_hi);
    ex.res_sel = 2'd2;
    step();
    check({tag, "_lo"}, ex.alu_out_m, exp_lo);
  endtask

  task automatic rand_alu();
    logic [31:0] v1, v2, imm, fm, fw, pc, a, rt, b, res;
    logic [4:0]  a3;
    int op, sh, rs;
    logic [1:0] fa, fb;
    logic bi;
    v1 = $urandom; v2 = $urandom; imm = $urandom; fm = $urandom; fw = $urandom;
    pc = $urandom; a3 = 5'($urandom);
    op = int'($urandom_range(0, 15)); sh = int'($urandom_range(0, 31));
    fa = 2'($urandom); fb = 2'($urandom); bi = 1'($urandom); rs = int'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) v1 = 32'h7FFFFFFF;
    idle_inputs();
    ex.v1_e = v1; ex.v2_e = v2; ex.e32_e = imm; ex.fwd_m_data = fm; ex.fwd_w_data = fw;
    ex.pc_e = pc; ex.pc4_e = pc + 32'd4; ex.a3_e = a3; ex.alu_op = 4'(op);
    ex.shamt_e = 5'(sh); ex.fwd_a_sel = fa; ex.fwd_b_sel = fb; ex.b_imm = bi;
    ex.res_sel = 2'(rs);
    a  = ref_fwd(fa, v1, fm, fw);
    rt = ref_fwd(fb, v2, fm, fw);
    b  = bi ? imm : rt;
    case (rs)
      1: res = m_hi;
      2: res = m_lo;
      3: res = pc + 32'd8;
      default: res = ref_alu(op, a, b, sh);
    endcase
    step();
    check_em($sformatf("rnd_op%0d_rs%0d", op, rs), res, rt, a3, pc, pc + 32'd4, ref_ovf(op, a, b));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check_em("reset", 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
    check("reset_busy", 32'(ex.md_busy), 32'd0);
    reset = 1'b0;

    ex.v1_e = 32'd5; ex.v2_e = 32'd3; ex.alu_op = ALU_SUBU;
    step();
    check("subu_plain", ex.alu_out_m, 32'd2);
    ex.fwd_a_sel = 2'd1; ex.fwd_m_data = 32'd10;
    step();
    check("subu_fwd_m", ex.alu_out_m, 32'd7);

    md_run("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, MULT_N);
    read_hilo("multu", 32'h1, 32'hFFFFFFFE);
    md_run("mult", MD_MULT, 32'hFFFFFFFD, 32'd5, MULT_N);
    read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFF1);
    md_run("div", MD_DIV, 32'hFFFFFFF9, 32'd2, DIV_N);
    read_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    md_run("mthi", MD_MTHI, 32'h11, 32'h0, 0);
    md_run("mtlo", MD_MTLO, 32'h11, 32'h0, 0);
    md_run("divu0", MD_DIVU, 32'd7, 32'd0, DIV_N);
    read_hilo("divu0", 32'h11, 32'h11);

    idle_inputs();
    ex.v1_e = 32'h7FFFFFFF; ex.e32_e = 32'd1; ex.b_imm = 1'b1; ex.alu_op = ALU_ADDU;
    step();
    check("ovf_alu", ex.alu_out_m, 32'h80000000);
    check("ovf_flag", 32'(ex.ovf_m), 32'(OVF_ON));

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [31:0] a, b;
        logic [2:0] op;
        op = 3'($urandom_range(1, 6));
        a = $urandom; b = $urandom;
        if ($urandom_range(0, 7) == 0) b = 32'h0;
        if (op == MD_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
        md_run($sformatf("rnd_md%0d", op), op, a, b,
               (op <= 3'd2) ? int'(MULT_N) : (op <= 3'd4) ? int'(DIV_N) : 0);
      end else begin
        rand_alu();
      end
    end
    read_hilo("rnd_final", m_hi, m_lo);

    // Reset in the middle of a divide.
    idle_inputs();
    ex.v1_e = 32'd100; ex.v2_e = 32'd3; ex.md_op = MD_DIV; ex.md_start = 1'b1;
    step();
    ex.md_start = 1'b0; ex.md_op = '0;
    step(); step(); step();
    check("abort_busy_before", 32'(ex.md_busy), 32'd1);
    reset = 1'b1;
    ex.v1_e = 32'h1234; ex.v2_e = 32'h5678; ex.a3_e = 5'd5; ex.pc_e = 32'h400;
    ex.pc4_e = 32'h404; ex.alu_op = ALU_ADDU;
    step();
    check("abort_busy", 32'(ex.md_busy), 32'd0);
    check_em("abort", 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    read_hilo("abort", 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
